// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: hazard inputs from DE/EX/MEM, stage controls back,
// plus the controller state on dbg_state (RUN=0, FLUSH=1, MEM_WAIT=2, HALT=3).
interface hazard_ctrl_if;
  logic [4:0] de_adr1;
  logic [4:0] de_adr2;
  logic       de_rs1_used;
  logic       de_rs2_used;
  logic [4:0] ex_rd;
  logic       ex_memRead;
  logic       br_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_en;
  logic       if_de_en;
  logic       de_ex_en;
  logic       ex_mem_en;
  logic       if_de_flush;
  logic       de_ex_flush;
  logic       mem_wb_bubble;
  logic       mem_err;
  logic [1:0] dbg_state;

  // Handshake: the data memory completes an access in the cycle where mem_req and
  // mem_ready are both high; mem_req high with mem_ready low freezes the pipeline.
  modport master (
    output de_adr1, de_adr2, de_rs1_used, de_rs2_used, ex_rd, ex_memRead,
           br_taken, mem_req, mem_ready,
    input  pc_en, if_de_en, de_ex_en, ex_mem_en, if_de_flush, de_ex_flush,
           mem_wb_bubble, mem_err, dbg_state
  );

  modport slave (
    input  de_adr1, de_adr2, de_rs1_used, de_rs2_used, ex_rd, ex_memRead,
           br_taken, mem_req, mem_ready,
    output pc_en, if_de_en, de_ex_en, ex_mem_en, if_de_flush, de_ex_flush,
           mem_wb_bubble, mem_err, dbg_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing controller: memory freeze, branch flush, load-use stall
// and memory-timeout watchdog. Define HAZARD_STATS_EN to add stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam logic [15:0] TIMEOUT_W = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        mem_err_q, mem_err_d;

  logic freeze;
  logic lu;
  logic pc_en, if_de_en, de_ex_en, ex_mem_en;
  logic if_de_flush, de_ex_flush, mem_wb_bubble;

  assign freeze = hz.mem_req & ~hz.mem_ready;
  assign lu     = hz.ex_memRead & (hz.ex_rd != 5'd0) &
                  ((hz.de_rs1_used & (hz.de_adr1 == hz.ex_rd)) |
                   (hz.de_rs2_used & (hz.de_adr2 == hz.ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wcnt_q    <= 16'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next state; wcnt counts consecutive freeze cycles, the first one taken in RUN/FLUSH.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN, FLUSH: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          wcnt_d  = 16'd1;
        end else if (hz.br_taken) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          wcnt_d  = 16'd0;
          state_d = hz.br_taken ? FLUSH : RUN;
        end else if (wcnt_q == TIMEOUT_W) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Stage controls; priority order matters, a held branch is applied on freeze release.
  always_comb begin
    pc_en         = 1'b1;
    if_de_en      = 1'b1;
    de_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_de_flush   = 1'b0;
    de_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst_n) begin
      pc_en         = 1'b0;
      if_de_en      = 1'b0;
      de_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      if_de_flush   = 1'b1;
      de_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (state_q == HALT) begin
      pc_en     = 1'b0;
      if_de_en  = 1'b0;
      de_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (freeze) begin
      pc_en         = 1'b0;
      if_de_en      = 1'b0;
      de_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (hz.br_taken) begin
      if_de_flush = 1'b1;
      de_ex_flush = 1'b1;
    end else if (state_q == FLUSH) begin
      if_de_flush = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      if_de_en    = 1'b0;
      de_ex_flush = 1'b1;
    end
  end

  assign hz.pc_en         = pc_en;
  assign hz.if_de_en      = if_de_en;
  assign hz.de_ex_en      = de_ex_en;
  assign hz.ex_mem_en     = ex_mem_en;
  assign hz.if_de_flush   = if_de_flush;
  assign hz.de_ex_flush   = de_ex_flush;
  assign hz.mem_wb_bubble = mem_wb_bubble;
  assign hz.mem_err       = mem_err_q;
  assign hz.dbg_state     = state_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pc_en && (state_q != HALT) && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_de_flush && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a rule-level reference model
// that tracks pending flush, consecutive freeze length and the halted flag.
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Reference model state
  bit m_halt;
  bit m_flush_pend;
  int m_freeze_run;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  // {state[1:0], pc_en, if_de_en, de_ex_en, ex_mem_en, if_de_flush, de_ex_flush, mem_wb_bubble, mem_err}
  function automatic logic [9:0] model_expect();
    logic freeze, lu;
    logic [1:0] st;
    logic [7:0] o;
    freeze = hz.mem_req && !hz.mem_ready;
    lu = hz.ex_memRead && (hz.ex_rd != 0) &&
         ((hz.de_rs1_used && hz.de_adr1 == hz.ex_rd) || (hz.de_rs2_used && hz.de_adr2 == hz.ex_rd));
    if (m_halt) st = 2'd3;
    else if (m_freeze_run > 0) st = 2'd2;
    else if (m_flush_pend) st = 2'd1;
    else st = 2'd0;
    if (!rst_n) return {2'd0, 8'b0000_1110};
    if (m_halt) o = 8'b0000_0001;
    else if (freeze) o = 8'b0000_0010;
    else if (hz.br_taken) o = 8'b1111_1100;
    else if (m_flush_pend) o = 8'b1111_1000;
    else if (lu) o = 8'b0011_0100;
    else o = 8'b1111_0000;
    return {st, o};
  endfunction

  task automatic check(input string tag);
    logic [9:0] exp, obs;
    exp_q.push_back(model_expect());
    exp = exp_q.pop_front();
    obs = {hz.dbg_state, hz.pc_en, hz.if_de_en, hz.de_ex_en, hz.ex_mem_en,
           hz.if_de_flush, hz.de_ex_flush, hz.mem_wb_bubble, hz.mem_err};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n || m_halt) return;
    if (hz.mem_req && !hz.mem_ready) begin
      m_freeze_run++;
      m_flush_pend = 1'b0;
      if (m_freeze_run == TO + 1) m_halt = 1'b1;
    end else begin
      m_freeze_run = 0;
      m_flush_pend = hz.br_taken;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step(input string tag);
    #1;
    check(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    hz.de_adr1 = 5'd0;  hz.de_adr2 = 5'd0;
    hz.de_rs1_used = 1'b0; hz.de_rs2_used = 1'b0;
    hz.ex_rd = 5'd0; hz.ex_memRead = 1'b0;
    hz.br_taken = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_halt = 1'b0; m_flush_pend = 1'b0; m_freeze_run = 0;
    #1;
    check(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic freeze_inputs();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset("reset");
    step("idle");

    // Load-use: one bubble, then the load has left EX
    hz.ex_memRead = 1'b1; hz.ex_rd = 5'd5; hz.de_adr2 = 5'd5; hz.de_rs2_used = 1'b1;
    step("load_use");
    hz.ex_memRead = 1'b0; hz.ex_rd = 5'd7;
    step("load_use_after");
    hz.ex_memRead = 1'b1; hz.ex_rd = 5'd0; hz.de_adr1 = 5'd0; hz.de_rs1_used = 1'b1; hz.de_adr2 = 5'd0;
    step("load_x0");
    idle_inputs();

    // Taken branch
    hz.br_taken = 1'b1;
    step("branch");
    hz.br_taken = 1'b0;
    step("branch_flush");
    step("branch_run");

    // Three-cycle memory wait
    for (int i = 0; i < 3; i++) begin
      freeze_inputs();
      step("mem_wait");
    end
    hz.mem_ready = 1'b1;
    step("mem_release");
    idle_inputs();
    step("mem_after");

    // Timeout: five freeze cycles then HALT, sticky until reset
    for (int i = 0; i < TO + 1; i++) begin
      freeze_inputs();
      step("timeout_wait");
    end
    step("halt_frozen");
    hz.mem_ready = 1'b1; hz.br_taken = 1'b1;
    step("halt_release");
    idle_inputs();
    step("halt_idle");
    do_reset("halt_reset");
    step("post_halt_run");

    // Branch held in EX across a freeze
    hz.br_taken = 1'b1;
    freeze_inputs();
    step("br_frozen1");
    step("br_frozen2");
    hz.mem_ready = 1'b1;
    step("br_release");
    idle_inputs();
    step("br_release_flush");
    step("br_release_run");

    // Freeze during FLUSH drops FLUSH
    hz.br_taken = 1'b1;
    step("br_then_freeze");
    hz.br_taken = 1'b0;
    freeze_inputs();
    step("freeze_in_flush");
    hz.mem_ready = 1'b1;
    step("freeze_in_flush_rel");
    idle_inputs();
    step("freeze_in_flush_after");

    // Reset mid-wait, then a full-length wait must still be allowed
    freeze_inputs();
    step("pre_reset_wait1");
    step("pre_reset_wait2");
    do_reset("reset_mid_wait");
    idle_inputs();
    step("after_mid_reset");
    for (int i = 0; i < TO; i++) begin
      freeze_inputs();
      step("wait_after_reset");
    end
    hz.mem_ready = 1'b1;
    step("wait_after_reset_rel");
    idle_inputs();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        do_reset("rand_reset");
      end
      hz.de_adr1     = 5'($urandom_range(0, 3));
      hz.de_adr2     = 5'($urandom_range(0, 3));
      hz.de_rs1_used = 1'($urandom_range(0, 1));
      hz.de_rs2_used = 1'($urandom_range(0, 1));
      hz.ex_rd       = 5'($urandom_range(0, 3));
      hz.ex_memRead  = 1'($urandom_range(0, 1));
      hz.br_taken    = ($urandom_range(0, 5) == 0);
      if ((n % 100) >= 90 && (n % 100) < 96) begin
        freeze_inputs();
      end else begin
        hz.mem_req   = ($urandom_range(0, 2) == 0);
        hz.mem_ready = 1'($urandom_range(0, 1));
      end
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
